// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the multi-cycle control sequencer
package control_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_ROR   = 3'd1;
   localparam logic [2:0] OP_NAND  = 3'd2;
   localparam logic [2:0] OP_LOAD  = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_MOVE  = 3'd5;
   localparam logic [2:0] OP_BNE   = 3'd6;
   localparam logic [2:0] OP_SET   = 3'd7;

   // Narrow ALU selects; users zero-extend to their own ALUOp width.
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_ROR   = 3'd1;
   localparam logic [2:0] ALU_NAND  = 3'd2;
   localparam logic [2:0] ALU_PASSA = 3'd3;
   localparam logic [2:0] ALU_PASSB = 3'd4;
   localparam logic [2:0] ALU_SUB   = 3'd5;

   typedef struct packed {
      logic ir_load;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic branch;
      logic pc_en;
      logic busy;
      logic err;
   } ctrl_t;

   function automatic logic [2:0] alu_sel(input logic [2:0] op);
      logic [2:0] sel;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_ROR:  sel = ALU_ROR;
         OP_NAND: sel = ALU_NAND;
         OP_SET:  sel = ALU_PASSB;
         OP_BNE:  sel = ALU_SUB;
         default: sel = ALU_PASSA;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - Moore output decode from state and latched opcode to datapath controls
module control_decode
   import control_pkg::*;
#(
   parameter int OP_WIDTH = 3
) (
   input  state_t              i_state,
   input  logic [2:0]          i_op,
   input  logic                i_br_taken,
   output ctrl_t               o_ctrl,
   output logic [OP_WIDTH-1:0] o_alu_op
);

   logic w_is_load;
   logic w_is_store;
   logic w_is_bne;
   logic w_is_set;

   assign w_is_load  = (i_op == OP_LOAD);
   assign w_is_store = (i_op == OP_STORE);
   assign w_is_bne   = (i_op == OP_BNE);
   assign w_is_set   = (i_op == OP_SET);

   always_comb begin
      o_ctrl   = '0;
      o_alu_op = OP_WIDTH'(ALU_PASSA);
      case (i_state)
         S_FETCH: begin
            o_ctrl.busy    = 1'b1;
            o_ctrl.ir_load = 1'b1;
         end
         S_DECODE: begin
            o_ctrl.busy = 1'b1;
         end
         S_EXEC: begin
            o_ctrl.busy    = 1'b1;
            o_ctrl.alu_src = w_is_set;
            o_alu_op       = OP_WIDTH'(alu_sel(i_op));
         end
         S_MEM: begin
            o_ctrl.busy      = 1'b1;
            o_ctrl.mem_read  = w_is_load;
            o_ctrl.mem_write = w_is_store;
         end
         S_WB: begin
            // ALU select is held through WB so the result stays stable for write-back.
            o_ctrl.busy       = 1'b1;
            o_ctrl.alu_src    = w_is_set;
            o_alu_op          = OP_WIDTH'(alu_sel(i_op));
            o_ctrl.pc_en      = 1'b1;
            o_ctrl.reg_write  = !(w_is_store || w_is_bne);
            o_ctrl.mem_to_reg = w_is_load;
            o_ctrl.branch     = w_is_bne && i_br_taken;
         end
         S_ERR: begin
            o_ctrl.err = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer with retired counter
module control_fsm
   import control_pkg::*;
#(
   parameter int MCODE_BITS = 3,
   parameter int OP_WIDTH   = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  instr_valid,
   input  logic [MCODE_BITS-1:0] instr,
   input  logic                  mem_ready,
   input  logic                  alu_zero,
   output logic                  ir_load,
   output logic                  RegWrite,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  MemtoReg,
   output logic                  ALUSrc,
   output logic                  Branch,
   output logic                  pc_en,
   output logic [OP_WIDTH-1:0]   ALUOp,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_W-1:0]      retired
);

   state_t                r_state;
   state_t                w_next;
   logic [MCODE_BITS-1:0] r_op_q;
   logic                  r_br_taken;
   logic                  r_done;
   logic [CNT_W-1:0]      r_retired;
   logic [2:0]            w_op;
   logic                  w_illegal;
   logic                  w_is_mem_op;
   ctrl_t                 w_ctrl;

   assign w_op        = r_op_q[2:0];
   // Shift rather than slice so the check stays legal when MCODE_BITS is exactly 3.
   assign w_illegal   = ((r_op_q >> 3) != '0);
   assign w_is_mem_op = (w_op == OP_LOAD) || (w_op == OP_STORE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH: begin
            if (halt_req)         w_next = S_IDLE;
            else if (instr_valid) w_next = S_DECODE;
         end
         S_DECODE: w_next = w_illegal ? S_ERR : S_EXEC;
         S_EXEC:   w_next = w_is_mem_op ? S_MEM : S_WB;
         S_MEM:    if (mem_ready) w_next = S_WB;
         S_WB:     w_next = S_FETCH;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op_q     <= '0;
         r_br_taken <= 1'b0;
         r_done     <= 1'b0;
         r_retired  <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_FETCH) && halt_req;
         if ((r_state == S_FETCH) && !halt_req && instr_valid)
            r_op_q <= instr;
         if (r_state == S_EXEC)
            r_br_taken <= (w_op == OP_BNE) && !alu_zero;
         if ((r_state == S_IDLE) && start)
            r_retired <= '0;
         else if ((r_state == S_WB) && (r_retired != '1))
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   control_decode #(
      .OP_WIDTH (OP_WIDTH)
   ) u_decode (
      .i_state    (r_state),
      .i_op       (w_op),
      .i_br_taken (r_br_taken),
      .o_ctrl     (w_ctrl),
      .o_alu_op   (ALUOp)
   );

   assign ir_load  = w_ctrl.ir_load;
   assign RegWrite = w_ctrl.reg_write;
   assign MemRead  = w_ctrl.mem_read;
   assign MemWrite = w_ctrl.mem_write;
   assign MemtoReg = w_ctrl.mem_to_reg;
   assign ALUSrc   = w_ctrl.alu_src;
   assign Branch   = w_ctrl.branch;
   assign pc_en    = w_ctrl.pc_en;
   assign busy     = w_ctrl.busy;
   assign err      = w_ctrl.err;
   assign done     = r_done;
   assign retired  = r_retired;

endmodule
